// File: rtl/ip_packet_rx.sv
// Receive-side Ethernet/IPv4 frame parser: filters frames addressed to the
// accelerator and captures source MAC, source IP and a fixed-size payload.
module ip_packet_rx #(
   parameter int USER_DATA_BYTES = 785
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
   input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
   input  logic [7:0]                   MAC_DATA_OUT,
   output logic                         MAC_DATA_READY,
   input  logic                         MAC_DATA_VALID,
   input  logic                         MAC_DATA_LAST,
   input  logic                         MAC_DATA_TUSER,
   output logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
   output logic [31:0]                  SRC_IP_ADDRESS,
   output logic [47:0]                  SRC_MAC_ADDRESS,
   output logic                         FRAME_READY,
   output logic                         PACKET_FOR_ACCELERATOR
);

   localparam int SRC_MAC_OFF = 6;
   localparam int SRC_IP_OFF  = 26;
   localparam int DST_IP_OFF  = 30;
   localparam int PAY_OFF     = 34;
   localparam int FINAL_IDX   = PAY_OFF + USER_DATA_BYTES - 1;

   typedef enum logic [1:0] {ETH_HDR, IP_HDR, PAYLOAD, DROP} state_t;

   state_t      state;
   logic [15:0] byte_cnt;
   logic        mac_ok;
   logic        ip_ok;
   logic        beat;
   logic [15:0] ip_rel;
   logic [7:0]  exp_mac_byte;
   logic [7:0]  exp_ip_byte;
   logic        mac_match_now;
   logic        ip_match_now;

   assign MAC_DATA_READY = ~ARESET;
   assign beat           = MAC_DATA_VALID & MAC_DATA_READY;
   assign ip_rel         = byte_cnt - 16'(DST_IP_OFF);

   always_comb begin
      exp_mac_byte = ACCELERATOR_MAC_ADDRESS[47:40];
      case (byte_cnt[2:0])
         3'd0:    exp_mac_byte = ACCELERATOR_MAC_ADDRESS[7:0];
         3'd1:    exp_mac_byte = ACCELERATOR_MAC_ADDRESS[15:8];
         3'd2:    exp_mac_byte = ACCELERATOR_MAC_ADDRESS[23:16];
         3'd3:    exp_mac_byte = ACCELERATOR_MAC_ADDRESS[31:24];
         3'd4:    exp_mac_byte = ACCELERATOR_MAC_ADDRESS[39:32];
         default: exp_mac_byte = ACCELERATOR_MAC_ADDRESS[47:40];
      endcase
   end

   always_comb begin
      exp_ip_byte = ACCELERATOR_IP_ADDRESS[31:24];
      case (ip_rel[1:0])
         2'd0:    exp_ip_byte = ACCELERATOR_IP_ADDRESS[7:0];
         2'd1:    exp_ip_byte = ACCELERATOR_IP_ADDRESS[15:8];
         2'd2:    exp_ip_byte = ACCELERATOR_IP_ADDRESS[23:16];
         default: exp_ip_byte = ACCELERATOR_IP_ADDRESS[31:24];
      endcase
   end

   // Running match flags; the first byte of each address restarts the AND chain.
   assign mac_match_now = ((byte_cnt == 16'd0) ? 1'b1 : mac_ok) & (MAC_DATA_OUT == exp_mac_byte);
   assign ip_match_now  = ((byte_cnt == 16'(DST_IP_OFF)) ? 1'b1 : ip_ok) & (MAC_DATA_OUT == exp_ip_byte);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state                  <= ETH_HDR;
         byte_cnt               <= 16'd0;
         mac_ok                 <= 1'b0;
         ip_ok                  <= 1'b0;
         FRAME_READY            <= 1'b0;
         PACKET_FOR_ACCELERATOR <= 1'b0;
      end else begin
         FRAME_READY <= 1'b0;
         if (beat) begin
            byte_cnt <= byte_cnt + 16'd1;
            case (state)
               ETH_HDR: begin
                  if (byte_cnt == 16'd0)
                     PACKET_FOR_ACCELERATOR <= 1'b0;
                  if (byte_cnt < 16'd6)
                     mac_ok <= mac_match_now;
                  if (byte_cnt == 16'd5 && !mac_match_now)
                     state <= DROP;
                  else if (byte_cnt == 16'd13)
                     state <= IP_HDR;
               end
               IP_HDR: begin
                  if (byte_cnt >= 16'(DST_IP_OFF))
                     ip_ok <= ip_match_now;
                  if (byte_cnt == 16'(PAY_OFF - 1)) begin
                     PACKET_FOR_ACCELERATOR <= mac_ok & ip_match_now;
                     state <= (mac_ok && ip_match_now) ? PAYLOAD : DROP;
                  end
               end
               PAYLOAD: begin
                  if (byte_cnt == 16'(FINAL_IDX)) begin
                     if (MAC_DATA_LAST)
                        FRAME_READY <= ~MAC_DATA_TUSER;
                     else
                        state <= DROP;
                  end
               end
               default: ;
            endcase
            // LAST always closes the frame, whatever state it arrives in.
            if (MAC_DATA_LAST) begin
               state    <= ETH_HDR;
               byte_cnt <= 16'd0;
            end
         end
      end
   end

   // Field capture: one byte lane per register slice, enabled by its frame offset.
   genvar i;
   generate
      for (i = 0; i < 6; i++) begin : g_src_mac
         always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET)
               SRC_MAC_ADDRESS[8*i +: 8] <= 8'd0;
            else if (beat && state == ETH_HDR && byte_cnt == 16'(SRC_MAC_OFF + i))
               SRC_MAC_ADDRESS[8*i +: 8] <= MAC_DATA_OUT;
         end
      end

      for (i = 0; i < 4; i++) begin : g_src_ip
         always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET)
               SRC_IP_ADDRESS[8*i +: 8] <= 8'd0;
            else if (beat && state == IP_HDR && byte_cnt == 16'(SRC_IP_OFF + i))
               SRC_IP_ADDRESS[8*i +: 8] <= MAC_DATA_OUT;
         end
      end

      for (i = 0; i < USER_DATA_BYTES; i++) begin : g_payload
         always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET)
               DATA_FRAME[8*i +: 8] <= 8'd0;
            else if (beat && state == PAYLOAD && byte_cnt == 16'(PAY_OFF + i))
               DATA_FRAME[8*i +: 8] <= MAC_DATA_OUT;
         end
      end
   endgenerate

endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed bench for ip_packet_rx: frames are built byte-by-byte, expected
// outcomes are queued on drive and popped once the frame has been sent.
module tb_ip_packet_rx;

   localparam int UDB = 785;

   logic             ACLK = 1'b0;
   logic             ARESET = 1'b1;
   logic [31:0]      ACCELERATOR_IP_ADDRESS = 32'hbbaaaaaa;
   logic [47:0]      ACCELERATOR_MAC_ADDRESS = 48'hccffffffffff;
   logic [7:0]       MAC_DATA_OUT = 8'd0;
   logic             MAC_DATA_READY;
   logic             MAC_DATA_VALID = 1'b0;
   logic             MAC_DATA_LAST = 1'b0;
   logic             MAC_DATA_TUSER = 1'b0;
   logic [UDB*8-1:0] DATA_FRAME;
   logic [31:0]      SRC_IP_ADDRESS;
   logic [47:0]      SRC_MAC_ADDRESS;
   logic             FRAME_READY;
   logic             PACKET_FOR_ACCELERATOR;

   ip_packet_rx #(.USER_DATA_BYTES(UDB)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .ACCELERATOR_IP_ADDRESS(ACCELERATOR_IP_ADDRESS),
      .ACCELERATOR_MAC_ADDRESS(ACCELERATOR_MAC_ADDRESS),
      .MAC_DATA_OUT(MAC_DATA_OUT), .MAC_DATA_READY(MAC_DATA_READY),
      .MAC_DATA_VALID(MAC_DATA_VALID), .MAC_DATA_LAST(MAC_DATA_LAST),
      .MAC_DATA_TUSER(MAC_DATA_TUSER), .DATA_FRAME(DATA_FRAME),
      .SRC_IP_ADDRESS(SRC_IP_ADDRESS), .SRC_MAC_ADDRESS(SRC_MAC_ADDRESS),
      .FRAME_READY(FRAME_READY), .PACKET_FOR_ACCELERATOR(PACKET_FOR_ACCELERATOR)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      bit         ready;
      bit         pfa;
      logic [7:0] smac_b;
      logic [7:0] sip_b;
      logic [7:0] fill;
      bit         inc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] byte_q[$];
   int         checks = 0;
   int         failures = 0;
   int         pulses = 0;
   int         exp_pulses = 0;
   logic       fr1, fr2, pfa_s;

   always @(negedge ACLK) if (FRAME_READY) pulses++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic build(input logic [47:0] dmac, input logic [31:0] dip, input int plen,
                        input logic [7:0] smac_b, input logic [7:0] sip_b,
                        input logic [7:0] fill, input bit inc);
      byte_q.delete();
      for (int k = 0; k < 6; k++) byte_q.push_back(dmac[8*k +: 8]);
      for (int k = 0; k < 6; k++) byte_q.push_back(smac_b + (inc ? 8'(k) : 8'd0));
      byte_q.push_back(8'h08);
      byte_q.push_back(8'h00);
      for (int k = 0; k < 12; k++) byte_q.push_back((k == 0) ? 8'h45 : 8'(k));
      for (int k = 0; k < 4; k++) byte_q.push_back(sip_b + (inc ? 8'(k) : 8'd0));
      for (int k = 0; k < 4; k++) byte_q.push_back(dip[8*k +: 8]);
      for (int k = 0; k < plen; k++) byte_q.push_back(fill + (inc ? 8'(k) : 8'd0));
   endtask

   // Drive the first n bytes of byte_q; LAST only on the final queued byte.
   task automatic send(input int n, input bit tuser);
      for (int i = 0; i < n; i++) begin
         @(negedge ACLK);
         MAC_DATA_VALID = 1'b1;
         MAC_DATA_OUT   = byte_q[i];
         MAC_DATA_LAST  = (i == byte_q.size() - 1);
         MAC_DATA_TUSER = tuser && (i == byte_q.size() - 1);
      end
      @(negedge ACLK);
      MAC_DATA_VALID = 1'b0;
      MAC_DATA_LAST  = 1'b0;
      MAC_DATA_TUSER = 1'b0;
   endtask

   task automatic check_frame();
      exp_t e;
      logic [47:0] em;
      logic [31:0] ei;
      int bad;
      fr1   = FRAME_READY;
      pfa_s = PACKET_FOR_ACCELERATOR;
      @(negedge ACLK);
      fr2 = FRAME_READY;
      if (sb.size() == 0) begin
         checks++; failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      chk("frame_ready", {63'd0, fr1}, {63'd0, e.ready});
      chk("frame_ready_width", {63'd0, fr2}, 64'd0);
      chk("pkt_for_acc", {63'd0, pfa_s}, {63'd0, e.pfa});
      if (e.ready) begin
         for (int k = 0; k < 6; k++) em[8*k +: 8] = e.smac_b + (e.inc ? 8'(k) : 8'd0);
         for (int k = 0; k < 4; k++) ei[8*k +: 8] = e.sip_b + (e.inc ? 8'(k) : 8'd0);
         chk("src_mac", {16'd0, SRC_MAC_ADDRESS}, {16'd0, em});
         chk("src_ip", {32'd0, SRC_IP_ADDRESS}, {32'd0, ei});
         bad = -1;
         for (int k = UDB - 1; k >= 0; k--)
            if (DATA_FRAME[8*k +: 8] !== e.fill + (e.inc ? 8'(k) : 8'd0)) bad = k;
         chk("payload_first_bad_index", 64'(bad), 64'hffffffffffffffff);
      end
   endtask

   task automatic run_frame(input logic [31:0] dip, input int plen, input logic [7:0] smac_b,
                            input logic [7:0] sip_b, input logic [7:0] fill, input bit inc,
                            input bit tuser, input bit exp_ready, input bit exp_pfa);
      exp_t e;
      build(ACCELERATOR_MAC_ADDRESS, dip, plen, smac_b, sip_b, fill, inc);
      e.ready = exp_ready; e.pfa = exp_pfa; e.smac_b = smac_b;
      e.sip_b = sip_b; e.fill = fill; e.inc = inc;
      sb.push_back(e);
      if (exp_ready) exp_pulses++;
      send(byte_q.size(), tuser);
      check_frame();
   endtask

   task automatic run_raw(input int n);
      exp_t e;
      byte_q.delete();
      for (int k = 0; k < n; k++) byte_q.push_back(8'hff);
      e.ready = 1'b0; e.pfa = 1'b0; e.smac_b = 8'd0;
      e.sip_b = 8'd0; e.fill = 8'd0; e.inc = 1'b0;
      sb.push_back(e);
      send(n, 1'b0);
      check_frame();
   endtask

   task automatic good(input logic [7:0] seed);
      run_frame(32'hbbaaaaaa, UDB, seed, seed + 8'h40, seed + 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      int lens[4];
      lens = '{765, 784, 786, 805};

      // Reset state
      repeat (3) @(negedge ACLK);
      chk("ready_in_reset", {63'd0, MAC_DATA_READY}, 64'd0);
      chk("frame_ready_reset", {63'd0, FRAME_READY}, 64'd0);
      chk("pfa_reset", {63'd0, PACKET_FOR_ACCELERATOR}, 64'd0);
      chk("src_mac_reset", {16'd0, SRC_MAC_ADDRESS}, 64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("ready_after_reset", {63'd0, MAC_DATA_READY}, 64'd1);

      // Happy path
      run_frame(32'hbbaaaaaa, UDB, 8'hdd, 8'hcc, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("happy_src_mac", {16'd0, SRC_MAC_ADDRESS}, {16'd0, 48'hdddddddddddd});
      chk("happy_src_ip", {32'd0, SRC_IP_ADDRESS}, {32'd0, 32'hcccccccc});
      chk("happy_payload_last", {56'd0, DATA_FRAME[8*UDB-1 -: 8]}, 64'h01);

      // Length errors each followed by a recovery frame
      for (int n = 0; n < 4; n++) begin
         run_frame(32'hbbaaaaaa, lens[n], 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
         good(8'h10 + 8'(n));
      end

      // Bad FCS
      run_frame(32'hbbaaaaaa, UDB, 8'h21, 8'h31, 8'h41, 1'b1, 1'b1, 1'b0, 1'b1);
      good(8'h50);

      // Destination IP mismatch
      run_frame(32'heeeeeeee, UDB, 8'h21, 8'h31, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
      good(8'h60);

      // Early termination
      run_raw(13);
      good(8'h70);
      run_raw(37);
      good(8'h78);

      // Reset mid-payload
      build(ACCELERATOR_MAC_ADDRESS, 32'hbbaaaaaa, UDB, 8'h90, 8'ha0, 8'hb0, 1'b1);
      byte_q.push_back(8'h00);
      send(400, 1'b0);
      ARESET = 1'b1;
      #1;
      chk("mid_reset_ready", {63'd0, MAC_DATA_READY}, 64'd0);
      chk("mid_reset_pfa", {63'd0, PACKET_FOR_ACCELERATOR}, 64'd0);
      chk("mid_reset_src_mac", {16'd0, SRC_MAC_ADDRESS}, 64'd0);
      chk("mid_reset_src_ip", {32'd0, SRC_IP_ADDRESS}, 64'd0);
      chk("mid_reset_data_nonzero", {63'd0, |DATA_FRAME}, 64'd0);
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("ready_after_mid_reset", {63'd0, MAC_DATA_READY}, 64'd1);
      good(8'hc0);

      chk("total_pulses", 64'(pulses), 64'(exp_pulses));
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
